irq_gateway_ctrl: RTL and testbench

- Collects up to six asynchronous external interrupt lines, synchronizes them and gates each one per source.
- Each line is latched as level- or edge-triggered pending state.
- Drives the machine-external-interrupt inputs `i_MEI_0..5` of the CSR block; `o_MEI[k]` connects to `i_MEI_k`.
- Firmware claims and completes interrupts through a small memory-mapped register port, so a source cannot re-interrupt while it is being serviced.

---
 rtl/irq_pkg.sv | 27 ++
 rtl/irq_gateway_ctrl_if.sv | 31 +++
 rtl/irq_gateway.sv | 68 ++++++
 rtl/irq_gateway_ctrl.sv | 103 ++++++++++
 tb/tb_irq_gateway_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt gateway: register map, mode encoding,
// source limit and the fixed-priority claim encoder.
package irq_pkg;

   localparam int MAX_IRQ_SRC = 6;

   localparam logic [1:0] IRQ_PENDING = 2'd0;
   localparam logic [1:0] IRQ_MODE    = 2'd1;
   localparam logic [1:0] IRQ_CLAIM   = 2'd2;
   localparam logic [1:0] IRQ_INSERV  = 2'd3;

   typedef enum logic {
      IRQ_LEVEL = 1'b0,
      IRQ_EDGE  = 1'b1
   } irq_mode_e;

   // Returns id+1 of the lowest set bit, 0 when nothing is set.
   function automatic logic [2:0] irq_first(input logic [MAX_IRQ_SRC-1:0] vec);
      irq_first = 3'd0;
      for (int i = MAX_IRQ_SRC - 1; i >= 0; i--) begin
         if (vec[i]) begin
            irq_first = 3'(i + 1);
         end
      end
   endfunction

endpackage

// File: rtl/irq_gateway_ctrl_if.sv
// Register port between firmware-side bus master and the interrupt gateway.
interface irq_gateway_ctrl_if;

   // Handshake: i_BUS_EN is a single-cycle strobe per access, always accepted;
   // o_BUS_ACK pulses exactly one cycle later with o_BUS_RDATA valid for reads.
   logic        i_BUS_EN;
   logic        i_BUS_WE;
   logic [1:0]  i_BUS_ADDR;
   logic [31:0] i_BUS_WDATA;
   logic [31:0] o_BUS_RDATA;
   logic        o_BUS_ACK;

   modport master (
      output i_BUS_EN,
      output i_BUS_WE,
      output i_BUS_ADDR,
      output i_BUS_WDATA,
      input  o_BUS_RDATA,
      input  o_BUS_ACK
   );

   modport slave (
      input  i_BUS_EN,
      input  i_BUS_WE,
      input  i_BUS_ADDR,
      input  i_BUS_WDATA,
      output o_BUS_RDATA,
      output o_BUS_ACK
   );

endinterface

// File: rtl/irq_gateway.sv
// One interrupt source: synchronizer, rising-edge detect, pending and
// in-service state, driven by claim/complete/w1c strobes from the top.
module irq_gateway
   import irq_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic irq_raw,
   input  logic mode,
   input  logic claim,
   input  logic complete,
   input  logic w1c,
   output logic pending,
   output logic in_service,
   output logic mei
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   dly_q, dly_d;
   logic                   pending_q, pending_d;
   logic                   in_service_q, in_service_d;
   logic                   sync_out;
   logic                   rise;

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign rise     = sync_out & ~dly_q;

   always_comb begin
      sync_d       = {sync_q[SYNC_STAGES-2:0], irq_raw};
      dly_d        = sync_out;
      pending_d    = pending_q;
      in_service_d = in_service_q;

      // Edge mode lets a new edge win over claim/w1c; level mode lets claim win.
      if (mode == IRQ_EDGE) begin
         pending_d = rise | (pending_q & ~(claim | w1c));
      end else begin
         pending_d = ~claim & (pending_q | (sync_out & ~in_service_q));
      end

      if (claim) begin
         in_service_d = 1'b1;
      end else if (complete) begin
         in_service_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q       <= '0;
         dly_q        <= 1'b0;
         pending_q    <= 1'b0;
         in_service_q <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         dly_q        <= dly_d;
         pending_q    <= pending_d;
         in_service_q <= in_service_d;
      end
   end

   assign pending    = pending_q;
   assign in_service = in_service_q;
   assign mei        = pending_q & ~in_service_q;

endmodule

// File: rtl/irq_gateway_ctrl.sv
// Interrupt gateway controller: per-source gateways, MODE register, fixed
// priority claim encoder and the memory-mapped claim/complete register port.
module irq_gateway_ctrl
   import irq_pkg::*;
#(
   parameter int N_SRC       = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic             i_CLK,
   input  logic             i_RSTn,
   input  logic [N_SRC-1:0] i_IRQ_SRC,
   output logic [N_SRC-1:0] o_MEI,
   irq_gateway_ctrl_if.slave bus
);

   logic [N_SRC-1:0]       mode_q, mode_d;
   logic [31:0]            rdata_q, rdata_d;
   logic                   ack_q, ack_d;

   logic [N_SRC-1:0]       pending_vec;
   logic [N_SRC-1:0]       inserv_vec;
   logic [N_SRC-1:0]       claim_vec;
   logic [N_SRC-1:0]       complete_vec;
   logic [N_SRC-1:0]       w1c_vec;
   logic [MAX_IRQ_SRC-1:0] elig_pad;
   logic [2:0]             claim_id;
   logic                   bus_rd;
   logic                   bus_wr;
   logic                   unused_wdata;

   assign bus_rd       = bus.i_BUS_EN & ~bus.i_BUS_WE;
   assign bus_wr       = bus.i_BUS_EN &  bus.i_BUS_WE;
   assign unused_wdata = ^bus.i_BUS_WDATA;

   always_comb begin
      elig_pad              = '0;
      elig_pad[N_SRC-1:0]   = pending_vec & ~inserv_vec;
   end

   assign claim_id = irq_first(elig_pad);

   assign w1c_vec = (bus_wr && bus.i_BUS_ADDR == IRQ_PENDING) ?
                    bus.i_BUS_WDATA[N_SRC-1:0] : '0;

   for (genvar i = 0; i < N_SRC; i++) begin : g_src
      // Only the winning source sees the claim; out-of-range complete ids match nothing.
      assign claim_vec[i]    = bus_rd && (bus.i_BUS_ADDR == IRQ_CLAIM) &&
                               (claim_id == 3'(i + 1));
      assign complete_vec[i] = bus_wr && (bus.i_BUS_ADDR == IRQ_CLAIM) &&
                               (bus.i_BUS_WDATA[2:0] == 3'(i + 1));

      irq_gateway #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_gw (
         .clk        (i_CLK),
         .rst_n      (i_RSTn),
         .irq_raw    (i_IRQ_SRC[i]),
         .mode       (mode_q[i]),
         .claim      (claim_vec[i]),
         .complete   (complete_vec[i]),
         .w1c        (w1c_vec[i]),
         .pending    (pending_vec[i]),
         .in_service (inserv_vec[i]),
         .mei        (o_MEI[i])
      );
   end

   always_comb begin
      mode_d  = mode_q;
      rdata_d = rdata_q;
      ack_d   = bus.i_BUS_EN;

      if (bus_wr && bus.i_BUS_ADDR == IRQ_MODE) begin
         mode_d = bus.i_BUS_WDATA[N_SRC-1:0];
      end

      if (bus_rd) begin
         case (bus.i_BUS_ADDR)
            IRQ_PENDING: rdata_d = 32'(pending_vec);
            IRQ_MODE:    rdata_d = 32'(mode_q);
            IRQ_CLAIM:   rdata_d = 32'(claim_id);
            IRQ_INSERV:  rdata_d = 32'(inserv_vec);
            default:     rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         mode_q  <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
      end
   end

   assign bus.o_BUS_RDATA = rdata_q;
   assign bus.o_BUS_ACK   = ack_q;

endmodule

// File: tb/tb_irq_gateway_ctrl.sv
// Bench for irq_gateway_ctrl: directed scenarios plus random traffic, checked
// against a cycle-level reference model of the pending/in-service rules.
module tb_irq_gateway_ctrl;

   localparam int N  = 6;
   localparam int SS = 2;

   logic         i_CLK = 1'b0;
   logic         i_RSTn = 1'b0;
   logic [N-1:0] i_IRQ_SRC = '0;
   logic [N-1:0] o_MEI;
   logic [N-1:0] irq_cur = '0;

   irq_gateway_ctrl_if bus ();

   irq_gateway_ctrl #(
      .N_SRC       (N),
      .SYNC_STAGES (SS)
   ) dut (
      .i_CLK     (i_CLK),
      .i_RSTn    (i_RSTn),
      .i_IRQ_SRC (i_IRQ_SRC),
      .o_MEI     (o_MEI),
      .bus       (bus)
   );

   always #5 i_CLK = ~i_CLK;

   int total = 0;
   int bad   = 0;

   logic [31:0]  exp_q[$];
   logic [N-1:0] m_pend, m_insv, m_mode, m_mei;
   logic [N-1:0] hist [SS+1];
   logic [31:0]  m_last_rd;
   logic         m_ack;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: the line seen by the gateway is the raw line delayed by
   // SS cycles; an edge is that delayed line rising from the cycle before.
   task automatic model_step();
      logic [N-1:0] s, rise, elig, cl, cp, w1c, np, ni;
      logic [31:0]  rd;
      int           id;
      int           cid;
      s    = hist[SS-1];
      rise = s & ~hist[SS];
      elig = m_pend & ~m_insv;
      id   = -1;
      for (int i = N - 1; i >= 0; i--) if (elig[i]) id = i;
      cl = '0; cp = '0; w1c = '0;
      rd = m_last_rd;
      if (bus.i_BUS_EN && !bus.i_BUS_WE) begin
         case (bus.i_BUS_ADDR)
            2'd0: rd = 32'(m_pend);
            2'd1: rd = 32'(m_mode);
            2'd2: begin
               rd = (id < 0) ? 32'd0 : 32'(id + 1);
               if (id >= 0) cl[id] = 1'b1;
            end
            default: rd = 32'(m_insv);
         endcase
      end
      if (bus.i_BUS_EN && bus.i_BUS_WE) begin
         cid = int'(bus.i_BUS_WDATA[2:0]);
         if (bus.i_BUS_ADDR == 2'd2 && cid >= 1 && cid <= N) cp[cid-1] = 1'b1;
         if (bus.i_BUS_ADDR == 2'd0) w1c = bus.i_BUS_WDATA[N-1:0];
         if (bus.i_BUS_ADDR == 2'd1) m_mode <= bus.i_BUS_WDATA[N-1:0];
      end
      for (int i = 0; i < N; i++) begin
         if (m_mode[i]) np[i] = rise[i] | (m_pend[i] & ~cl[i] & ~w1c[i]);
         else           np[i] = !cl[i] && (m_pend[i] || (s[i] && !m_insv[i]));
      end
      ni = (m_insv | cl) & ~cp;
      if (bus.i_BUS_EN) exp_q.push_back(rd);
      m_pend    <= np;
      m_insv    <= ni;
      m_mei     <= np & ~ni;
      m_last_rd <= rd;
      m_ack     <= bus.i_BUS_EN;
      hist[0]   <= i_IRQ_SRC;
      for (int k = 1; k <= SS; k++) hist[k] <= hist[k-1];
   endtask

   always @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         m_pend <= '0; m_insv <= '0; m_mode <= '0; m_mei <= '0;
         m_last_rd <= '0; m_ack <= 1'b0;
         for (int k = 0; k <= SS; k++) hist[k] <= '0;
         exp_q.delete();
      end else begin
         model_step();
      end
   end

   // Monitor: compares every cycle and pops one expectation per acknowledge.
   always @(negedge i_CLK) begin
      chk("mei", 32'(o_MEI), 32'(m_mei));
      chk("ack", 32'(bus.o_BUS_ACK), 32'(m_ack));
      if (bus.o_BUS_ACK) begin
         if (exp_q.size() == 0) begin
            chk("ack_unexpected", 32'd1, 32'd0);
         end else begin
            chk("rdata", bus.o_BUS_RDATA, exp_q.pop_front());
         end
      end
   end

   task automatic cyc(input logic en, input logic we, input logic [1:0] addr,
                      input logic [31:0] wd);
      @(posedge i_CLK);
      #1;
      bus.i_BUS_EN    = en;
      bus.i_BUS_WE    = we;
      bus.i_BUS_ADDR  = addr;
      bus.i_BUS_WDATA = wd;
      i_IRQ_SRC       = irq_cur;
   endtask

   task automatic rd(input logic [1:0] a);
      cyc(1'b1, 1'b0, a, 32'd0);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      cyc(1'b1, 1'b1, a, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 32'd0);
   endtask

   task automatic pulse(input int src);
      irq_cur[src] = 1'b1;
      idle(1);
      irq_cur[src] = 1'b0;
   endtask

   initial begin
      bus.i_BUS_EN = 1'b0; bus.i_BUS_WE = 1'b0;
      bus.i_BUS_ADDR = '0; bus.i_BUS_WDATA = '0;
      repeat (3) @(posedge i_CLK);
      #2;
      chk("reset_mei", 32'(o_MEI), 32'd0);
      chk("reset_ack", 32'(bus.o_BUS_ACK), 32'd0);
      chk("reset_rdata", bus.o_BUS_RDATA, 32'd0);
      @(negedge i_CLK);
      i_RSTn = 1'b1;
      for (int a = 0; a < 4; a++) rd(2'(a));
      idle(2);

      // Level source 2: latency, claim, complete with the line still high
      irq_cur[2] = 1'b1;
      idle(5);
      rd(2'd2);
      idle(3);
      wr(2'd2, 32'd3);
      idle(4);
      irq_cur[2] = 1'b0;
      rd(2'd2);
      idle(3);
      wr(2'd2, 32'd3);
      idle(3);

      // Edge source 0: capture while in service, re-interrupt after complete
      wr(2'd1, 32'h01);
      pulse(0);
      idle(4);
      rd(2'd0);
      rd(2'd2);
      pulse(0);
      idle(4);
      rd(2'd0);
      rd(2'd3);
      wr(2'd2, 32'd1);
      idle(3);
      rd(2'd2);
      wr(2'd2, 32'd1);
      idle(2);

      // Sources 1, 4, 5 together: priority order then empty claim
      irq_cur = 6'b110010;
      idle(1);
      irq_cur = '0;
      idle(4);
      for (int k = 0; k < 4; k++) rd(2'd2);
      rd(2'd3);
      wr(2'd2, 32'd2); wr(2'd2, 32'd5); wr(2'd2, 32'd6);
      idle(2);

      // Edge source 3: edge coincident with claim, then with W1C
      wr(2'd1, 32'h08);
      pulse(3);
      idle(4);
      pulse(3);
      idle(1);
      rd(2'd2);
      rd(2'd0);
      wr(2'd0, 32'h08);
      rd(2'd0);
      pulse(3);
      idle(1);
      wr(2'd0, 32'h08);
      rd(2'd0);
      wr(2'd0, 32'h08);
      rd(2'd0);
      wr(2'd2, 32'd7);
      rd(2'd3);
      wr(2'd2, 32'd0);
      rd(2'd3);
      wr(2'd2, 32'd4);
      rd(2'd3);

      // MODE change while pending keeps pending
      irq_cur[5] = 1'b1;
      idle(4);
      irq_cur[5] = 1'b0;
      wr(2'd1, 32'h20);
      rd(2'd0);
      wr(2'd1, 32'h00);
      rd(2'd0);
      rd(2'd2);
      wr(2'd2, 32'd6);
      idle(2);

      // Random traffic, back-to-back accesses allowed
      for (int c = 0; c < 600; c++) begin
         logic [31:0] wd;
         logic [1:0]  a;
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 7) == 0) irq_cur[b] = ~irq_cur[b];
         a  = 2'($urandom_range(0, 3));
         wd = $urandom;
         if (a == 2'd2) wd[2:0] = 3'($urandom_range(0, 7));
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd);
      end

      // Asynchronous reset in the cycle after a claim
      irq_cur = '0;
      idle(5);
      for (int k = 1; k <= N; k++) wr(2'd2, 32'(k));
      wr(2'd1, 32'h00);
      irq_cur = 6'b000011;
      idle(6);
      rd(2'd2);
      idle(1);
      #2;
      i_RSTn = 1'b0;
      #1;
      chk("async_rst_mei", 32'(o_MEI), 32'd0);
      chk("async_rst_ack", 32'(bus.o_BUS_ACK), 32'd0);
      chk("async_rst_rdata", bus.o_BUS_RDATA, 32'd0);
      repeat (2) @(posedge i_CLK);
      @(negedge i_CLK);
      i_RSTn = 1'b1;
      idle(6);
      for (int a = 0; a < 4; a++) rd(2'(a));
      irq_cur = '0;
      idle(4);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
